// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and width helpers for the display scanner.
//   slot_state_t : phase within one digit slot (blanked gap, then digit shown)
//   nibble_t     : one hex digit
//   cnt_w()      : slot counter width for a given PRESCALE
//   idx_w()      : digit index width for a given NUM_DIGITS
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } slot_state_t;

    typedef logic [3:0] nibble_t;

    // Width that holds 0..prescale-1 (CNT_W); never below one bit.
    function automatic int cnt_w(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

    // Width that holds 0..num_digits-1 (IDX_W); never below one bit.
    function automatic int idx_w(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen
// Slot prescaler and digit-index counter for the display scanner.
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   o_cnt        position inside the current digit slot, 0..PRESCALE-1
//   o_index      digit currently being scanned, 0..NUM_DIGITS-1
//   o_in_gap     slot is in its blanked lead-in (cnt < GAP_CYCLES)
//   o_slot_last  last cycle of the current slot
//   o_frame_last last cycle of the last digit's slot (frame boundary)
// ---------------------------------------------------------------------------
module scan_tick_gen
    import display_pkg::*;
#(
    parameter int PRESCALE   = 1000,
    parameter int GAP_CYCLES = 16,
    parameter int NUM_DIGITS = 4,
    localparam int CNT_W     = cnt_w(PRESCALE),
    localparam int IDX_W     = idx_w(NUM_DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_cnt,
    output logic [IDX_W-1:0] o_index,
    output logic             o_in_gap,
    output logic             o_slot_last,
    output logic             o_frame_last
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_index;
    logic             w_slot_last;
    logic             w_index_last;

    assign w_slot_last  = (r_cnt == CNT_W'(PRESCALE - 1));
    assign w_index_last = (r_index == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_index <= '0;
        end else if (w_slot_last) begin
            r_cnt   <= '0;
            // NUM_DIGITS need not be a power of two, so wrap explicitly.
            r_index <= w_index_last ? '0 : r_index + 1'b1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // With no gap the compare against zero would be constant-false.
    generate
        if (GAP_CYCLES > 0) begin : g_gap
            assign o_in_gap = (r_cnt < CNT_W'(GAP_CYCLES));
        end else begin : g_no_gap
            assign o_in_gap = 1'b0;
        end
    endgenerate

    assign o_cnt        = r_cnt;
    assign o_index      = r_index;
    assign o_slot_last  = w_slot_last;
    assign o_frame_last = w_slot_last && w_index_last;

endmodule

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
// Time-multiplexes an N-digit hex word onto one shared seven-segment decoder
// and a one-hot digit-select bus, with a blanked gap at the start of every
// digit slot. New data is staged in a shadow register and promoted to the
// displayed (active) register only at a frame boundary.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   data_in      hex word, digit 0 = data_in[3:0] = rightmost
//   load         1-cycle strobe capturing data_in
//   display_on   0 forces blank output; scanning keeps running
//   digit_value  nibble to the decoder value input
//   digit_blank  decoder blank input
//   digit_sel    one-hot digit enable, one cycle behind digit_value
//   frame_start  pulse in the first cycle of digit 0's slot
//   pending      loaded data waiting for the next frame boundary
//
// Build option:
//   DISPLAY_SCANNER_LZB_EN  leading-zero blanking (digits above the most
//                           significant nonzero digit stay dark; digit 0
//                           is always shown)
// ---------------------------------------------------------------------------
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int GAP_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic                    display_on,
    output logic [3:0]              digit_value,
    output logic                    digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int CNT_W = cnt_w(PRESCALE);
    localparam int IDX_W = idx_w(NUM_DIGITS);

    logic [CNT_W-1:0]        w_cnt;
    logic [IDX_W-1:0]        w_index;
    logic                    w_in_gap;
    logic                    w_slot_last;
    logic                    w_frame_last;
    logic                    w_unused_slot_last;

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pending;

    logic [3:0]              r_value;
    logic                    r_blank;
    logic [NUM_DIGITS-1:0]   r_sel_pre;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic                    r_frame_start;

    slot_state_t             w_slot;
    nibble_t                 w_nib;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_show_mask;
    logic                    w_digit_shown;
    logic                    w_lit;

    scan_tick_gen #(
        .PRESCALE   (PRESCALE),
        .GAP_CYCLES (GAP_CYCLES),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_tick (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .o_cnt        (w_cnt),
        .o_index      (w_index),
        .o_in_gap     (w_in_gap),
        .o_slot_last  (w_slot_last),
        .o_frame_last (w_frame_last)
    );

    // Slot boundaries inside a frame need no action here.
    assign w_unused_slot_last = w_slot_last;

    // Shadow/active double buffer: a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= data_in;
            end
            if (w_frame_last) begin
                // A load landing on the boundary bypasses the shadow.
                if (load) begin
                    r_active <= data_in;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef DISPLAY_SCANNER_LZB_EN
    // Scan from the top digit down; everything from the first nonzero digit
    // downward is shown. Depends only on r_active, so it moves per frame.
    logic w_seen;
    always_comb begin
        w_seen      = 1'b0;
        w_show_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_active[i*4 +: 4] != 4'h0) begin
                w_seen = 1'b1;
            end
            w_show_mask[i] = w_seen || (i == 0);
        end
    end
`else
    assign w_show_mask = '1;
`endif

    always_comb begin
        w_nib         = '0;
        w_onehot      = '0;
        w_digit_shown = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_index == IDX_W'(i)) begin
                w_nib         = r_active[i*4 +: 4];
                w_onehot[i]   = 1'b1;
                w_digit_shown = w_show_mask[i];
            end
        end
    end

    assign w_slot = w_in_gap ? GAP : SHOW;
    assign w_lit  = (w_slot == SHOW) && display_on && w_digit_shown;

    // digit_sel goes through one extra stage to line up with the decoder's
    // own output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value       <= '0;
            r_blank       <= 1'b1;
            r_sel_pre     <= '0;
            r_sel         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_value       <= (w_slot == SHOW) ? w_nib : 4'h0;
            r_blank       <= !w_lit;
            r_sel_pre     <= w_lit ? w_onehot : '0;
            r_sel         <= r_sel_pre;
            r_frame_start <= (w_cnt == '0) && (w_index == '0);
        end
    end

    assign digit_value = r_value;
    assign digit_blank = r_blank;
    assign digit_sel   = r_sel;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule

// File: tb/tb_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_display_scanner
// Directed bench for display_scanner with NUM_DIGITS=4, PRESCALE=8, GAP=2.
// Expected outputs follow from the state number s (cycles since reset
// release): slot position s%8, digit (s/8)%4, frame start every 32 states.
// ---------------------------------------------------------------------------
module tb_display_scanner;

    localparam int ND  = 4;
    localparam int PS  = 8;
    localparam int GAP = 2;
`ifdef DISPLAY_SCANNER_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [15:0] data_in    = 16'h0;
    logic        load       = 1'b0;
    logic        display_on = 1'b1;
    logic [3:0]  digit_value;
    logic        digit_blank;
    logic [3:0]  digit_sel;
    logic        frame_start;
    logic        pending;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          s        = -1;
    int          p_s      = -1;
    logic        p_on     = 1'b0;
    logic [15:0] p_act    = 16'h0;

    display_scanner #(
        .NUM_DIGITS (ND),
        .PRESCALE   (PS),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .load        (load),
        .display_on  (display_on),
        .digit_value (digit_value),
        .digit_blank (digit_blank),
        .digit_sel   (digit_sel),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (state %0d)", tag, got, exp, s);
    endtask

    // Digit d is lit unless leading-zero blanking hides it.
    function automatic logic shown(input int d, input logic [15:0] act);
        return !LZB || (d == 0) || ((act >> (4 * d)) != 16'h0);
    endfunction

    // One clock; act is the word expected to be displayed in this state.
    task automatic tick_check(input logic [15:0] act);
        logic       on_s;
        int         pos, dig, ppos, pdig;
        logic       eb;
        logic [3:0] ev;
        logic [3:0] es;
        on_s = display_on;
        @(posedge clk);
        #1;
        s++;
        pos = s % PS;
        dig = (s / PS) % ND;
        eb  = (pos < GAP) || !on_s || !shown(dig, act);
        ev  = (pos < GAP) ? 4'h0 : act[dig*4 +: 4];
        es  = 4'h0;
        if (p_s >= 0) begin
            ppos = p_s % PS;
            pdig = (p_s / PS) % ND;
            if (ppos >= GAP && p_on && shown(pdig, p_act)) es = 4'(1 << pdig);
        end
        check_eq("frame_start", 32'(frame_start), 32'((s % (PS * ND)) == 0));
        check_eq("digit_blank", 32'(digit_blank), 32'(eb));
        check_eq("digit_value", 32'(digit_value), 32'(ev));
        check_eq("digit_sel",   32'(digit_sel),   32'(es));
        p_s   = s;
        p_on  = on_s;
        p_act = act;
    endtask

    task automatic run_to(input int target, input logic [15:0] act);
        while (s < target) tick_check(act);
    endtask

    task automatic do_load(input logic [15:0] val, input logic [15:0] act);
        data_in = val;
        load    = 1'b1;
        tick_check(act);
        load    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_value"},   32'(digit_value), 32'h0);
        check_eq({tag, "_blank"},   32'(digit_blank), 32'h1);
        check_eq({tag, "_sel"},     32'(digit_sel),   32'h0);
        check_eq({tag, "_fstart"},  32'(frame_start), 32'h0);
        check_eq({tag, "_pending"}, 32'(pending),     32'h0);
    endtask

    initial begin
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Idle frames with blank data
        run_to(31, 16'h0);
        run_to(39, 16'h0);

        // Mid-frame load: old data until the boundary
        do_load(16'h12AF, 16'h0);
        check_eq("pending_set", 32'(pending), 32'h1);
        run_to(62, 16'h0);
        check_eq("pending_hold", 32'(pending), 32'h1);
        tick_check(16'h0);
        check_eq("pending_clr", 32'(pending), 32'h0);

        // Two loads in one frame: last wins
        run_to(69, 16'h12AF);
        do_load(16'h1111, 16'h12AF);
        run_to(74, 16'h12AF);
        do_load(16'h2222, 16'h12AF);
        check_eq("pending_2nd", 32'(pending), 32'h1);
        run_to(95, 16'h12AF);
        check_eq("pending_clr2", 32'(pending), 32'h0);

        // Load exactly on the boundary cycle goes straight to active
        run_to(126, 16'h2222);
        do_load(16'h3333, 16'h2222);
        check_eq("pending_direct", 32'(pending), 32'h0);

        // display_on low for 10 cycles mid-slot
        run_to(131, 16'h3333);
        display_on = 1'b0;
        repeat (10) tick_check(16'h3333);
        display_on = 1'b1;
        run_to(169, 16'h3333);

        // Leading-zero patterns
        do_load(16'h0040, 16'h3333);
        run_to(191, 16'h3333);
        run_to(199, 16'h0040);
        do_load(16'h0000, 16'h0040);
        run_to(223, 16'h0040);
        run_to(259, 16'h0000);

        // Reset asserted mid-slot with data pending
        do_load(16'hBEEF, 16'h0000);
        check_eq("pending_pre_rst", 32'(pending), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
